// File: rtl/wb_master_bridge.sv
// Wishbone classic single-cycle bus master: turns one core valid/ready request
// into one Wishbone read or write cycle, bounded by a watchdog timeout.
module wb_master_bridge #(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned DATA_W  = 32,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic                CLK_I,
  input  logic                RST_I,
  // core-side request/response
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  input  logic [DATA_W/8-1:0] req_sel,
  output logic                rsp_valid,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  // Wishbone master port
  output logic                CYC_O,
  output logic                STB_O,
  output logic                WE_O,
  output logic [ADDR_W-1:0]   ADR_O,
  output logic [DATA_W-1:0]   DAT_O,
  output logic [DATA_W/8-1:0] SEL_O,
  input  logic [DATA_W-1:0]   DAT_I,
  input  logic                ACK_I,
  input  logic                ERR_I
);

  localparam int unsigned SEL_W = DATA_W / 8;
  localparam int unsigned CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
  localparam bit TIMEOUT_EN = (TIMEOUT != 0);

  typedef enum logic {
    IDLE = 1'b0,
    BUS  = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic               cyc_q, cyc_d;
  logic               we_q, we_d;
  logic [ADDR_W-1:0]  adr_q, adr_d;
  logic [DATA_W-1:0]  dat_q, dat_d;
  logic [SEL_W-1:0]   sel_q, sel_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;
  logic               rsp_err_q, rsp_err_d;

  logic               timeout_hit;
  logic               done;

  assign timeout_hit = TIMEOUT_EN && (cnt_q == CNT_LAST);

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    cyc_d       = cyc_q;
    we_d        = we_q;
    adr_d       = adr_q;
    dat_d       = dat_q;
    sel_d       = sel_q;
    cnt_d       = cnt_q;
    rsp_valid_d = 1'b0;
    rsp_rdata_d = rsp_rdata_q;
    rsp_err_d   = rsp_err_q;
    done        = 1'b0;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          we_d    = req_we;
          adr_d   = req_addr;
          dat_d   = req_wdata;
          sel_d   = req_sel;
          cyc_d   = 1'b1;
          cnt_d   = '0;
          state_d = BUS;
        end
      end
      BUS: begin
        // Priority: slave error, then acknowledge, then watchdog
        if (ERR_I) begin
          done        = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else if (ACK_I) begin
          done      = 1'b1;
          rsp_err_d = 1'b0;
          if (!we_q) begin
            rsp_rdata_d = DAT_I;
          end
        end else if (timeout_hit) begin
          done        = 1'b1;
          rsp_err_d   = 1'b1;
          rsp_rdata_d = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end

        if (done) begin
          cyc_d       = 1'b0;
          we_d        = 1'b0;
          rsp_valid_d = 1'b1;
          state_d     = IDLE;
        end
      end
    endcase
  end

  // State and output registers
  always_ff @(posedge CLK_I) begin
    if (RST_I) begin
      state_q     <= IDLE;
      cyc_q       <= 1'b0;
      we_q        <= 1'b0;
      adr_q       <= '0;
      dat_q       <= '0;
      sel_q       <= '0;
      cnt_q       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      cyc_q       <= cyc_d;
      we_q        <= we_d;
      adr_q       <= adr_d;
      dat_q       <= dat_d;
      sel_q       <= sel_d;
      cnt_q       <= cnt_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_rdata_q <= rsp_rdata_d;
      rsp_err_q   <= rsp_err_d;
    end
  end

  assign req_ready = (state_q == IDLE);
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign CYC_O     = cyc_q;
  assign STB_O     = cyc_q;
  assign WE_O      = we_q;
  assign ADR_O     = adr_q;
  assign DAT_O     = dat_q;
  assign SEL_O     = sel_q;

endmodule

// File: tb/tb_wb_master_bridge.sv
// Randomized scoreboard bench for wb_master_bridge with a Wishbone RAM slave
// that follows a per-transaction response plan.
module tb_wb_master_bridge;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned SW = DW / 8;
  localparam int unsigned TO = 16;

  localparam int M_ACK  = 0;
  localparam int M_ERR  = 1;
  localparam int M_BOTH = 2;
  localparam int M_NONE = 3;

  typedef struct {
    bit            we;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
    logic [SW-1:0] sel;
    int            mode;
    int            waits;
    bit            abort;
    bit            force_dat;
    logic [DW-1:0] dat;
  } plan_t;

  typedef struct {
    bit            err;
    logic [DW-1:0] rdata;
  } exp_t;

  logic          CLK_I, RST_I;
  logic          req_valid, req_ready, req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic [SW-1:0] req_sel;
  logic          rsp_valid, rsp_err;
  logic [DW-1:0] rsp_rdata;
  logic          CYC_O, STB_O, WE_O;
  logic [AW-1:0] ADR_O;
  logic [DW-1:0] DAT_O;
  logic [SW-1:0] SEL_O;
  logic [DW-1:0] DAT_I;
  logic          ACK_I, ERR_I;

  wb_master_bridge #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
    .CLK_I(CLK_I), .RST_I(RST_I),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .req_sel(req_sel),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .CYC_O(CYC_O), .STB_O(STB_O), .WE_O(WE_O), .ADR_O(ADR_O),
    .DAT_O(DAT_O), .SEL_O(SEL_O), .DAT_I(DAT_I), .ACK_I(ACK_I), .ERR_I(ERR_I)
  );

  initial begin
    CLK_I = 1'b0;
    forever #5 CLK_I = ~CLK_I;
  end

  int            n_chk = 0;
  int            n_fail = 0;
  plan_t         plan_q[$];
  exp_t          exp_q[$];
  logic [DW-1:0] model_mem [16];
  logic [DW-1:0] slave_mem [16];
  logic [DW-1:0] model_rdata = '0;
  logic [DW-1:0] held_rdata = '0;
  bit            prev_inflight = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old_w,
                                          input logic [DW-1:0] new_w,
                                          input logic [SW-1:0] sel);
    logic [DW-1:0] r;
    r = old_w;
    for (int b = 0; b < int'(SW); b++) if (sel[b]) r[8*b +: 8] = new_w[8*b +: 8];
    return r;
  endfunction

  // Number of cycles STB_O should stay high for a given slave plan
  function automatic int exp_stb(input plan_t p);
    if (p.mode == M_NONE || p.waits >= int'(TO)) return int'(TO);
    return p.waits + 1;
  endfunction

  // Reference model: outcome of a transaction from the slave plan and request
  task automatic model_issue(input plan_t p);
    exp_t e;
    int   idx;
    idx = int'(p.addr[5:2]);
    if (p.mode != M_ACK || p.waits >= int'(TO)) begin
      e.err       = 1'b1;
      model_rdata = '0;
    end else begin
      e.err = 1'b0;
      if (p.we) model_mem[idx] = merge(model_mem[idx], p.wdata, p.sel);
      else      model_rdata = p.force_dat ? p.dat : model_mem[idx];
    end
    e.rdata = model_rdata;
    exp_q.push_back(e);
  endtask

  task automatic do_txn(input plan_t p, input int idle, input bit hold);
    bit ok;
    bit chk_b2b;
    chk_b2b = prev_inflight && (idle == 0);
    repeat (idle) @(negedge CLK_I);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge CLK_I);
      req_valid = 1'b1;
      req_we    = p.we;
      req_addr  = p.addr;
      req_wdata = p.wdata;
      req_sel   = p.sel;
      if (req_ready) begin
        if (chk_b2b) chk("accept_in_rsp_cycle", 64'(rsp_valid), 64'd1);
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      chk("accept_timeout", 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    plan_q.push_back(p);
    if (!p.abort) model_issue(p);
    @(posedge CLK_I);
    @(negedge CLK_I);
    chk("cyc_after_accept", 64'(CYC_O), 64'd1);
    if (!hold) req_valid = 1'b0;
    prev_inflight = !p.abort;
  endtask

  function automatic plan_t mk(input bit we, input logic [AW-1:0] addr,
                               input logic [DW-1:0] wdata, input logic [SW-1:0] sel,
                               input int mode, input int waits);
    plan_t p;
    p.we = we; p.addr = addr; p.wdata = wdata; p.sel = sel;
    p.mode = mode; p.waits = waits; p.abort = 1'b0;
    p.force_dat = 1'b0; p.dat = '0;
    return p;
  endfunction

  // Wishbone slave: follows the queued plan, checks bus stability, RAM behind it
  initial begin
    int    cyc;
    bit    have_p;
    plan_t p;
    cyc = 0; have_p = 1'b0;
    ACK_I = 1'b0; ERR_I = 1'b0; DAT_I = '0;
    forever begin
      @(negedge CLK_I);
      if (CYC_O === 1'b1) begin
        if (cyc == 0) begin
          have_p = (plan_q.size() != 0);
          if (have_p) p = plan_q.pop_front();
          else chk("cyc_without_request", 64'd1, 64'd0);
        end
        ACK_I = 1'b0; ERR_I = 1'b0; DAT_I = DW'($urandom);
        if (have_p) begin
          chk("adr_o", 64'(ADR_O), 64'(p.addr));
          chk("dat_o", 64'(DAT_O), 64'(p.wdata));
          chk("sel_o", 64'(SEL_O), 64'(p.sel));
          chk("we_o",  64'(WE_O),  64'(p.we));
          if (p.mode != M_NONE && cyc == p.waits) begin
            ACK_I = (p.mode == M_ACK || p.mode == M_BOTH);
            ERR_I = (p.mode == M_ERR || p.mode == M_BOTH);
            if (!p.we) DAT_I = p.force_dat ? p.dat : slave_mem[ADR_O[5:2]];
            else if (p.mode == M_ACK)
              slave_mem[ADR_O[5:2]] = merge(slave_mem[ADR_O[5:2]], DAT_O, SEL_O);
          end
        end
        cyc++;
      end else begin
        if (cyc != 0 && have_p && !p.abort) chk("stb_cycles", 64'(cyc), 64'(exp_stb(p)));
        cyc = 0;
        // Noise on the slave inputs while idle must be ignored
        ACK_I = 1'($urandom);
        ERR_I = ($urandom_range(3) == 0);
        DAT_I = DW'($urandom);
      end
    end
  end

  // Response monitor / scoreboard
  always @(negedge CLK_I) begin
    if (RST_I === 1'b0) begin
      chk("stb_eq_cyc", 64'(STB_O), 64'(CYC_O));
      if (rsp_valid === 1'b1) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_rsp_valid", 64'd1, 64'd0);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("rsp_err",   64'(rsp_err),   64'(e.err));
          chk("rsp_rdata", 64'(rsp_rdata), 64'(e.rdata));
          chk("ready_on_rsp", 64'(req_ready), 64'd1);
          chk("cyc_low_on_rsp", 64'(CYC_O), 64'd0);
          held_rdata = e.rdata;
        end
      end else begin
        chk("rdata_held", 64'(rsp_rdata), 64'(held_rdata));
      end
    end
  end

  initial begin
    plan_t p;
    int    r;
    RST_I = 1'b1;
    req_valid = 1'b0; req_we = 1'b0; req_addr = '0; req_wdata = '0; req_sel = '0;
    for (int i = 0; i < 16; i++) begin
      model_mem[i] = DW'($urandom);
      slave_mem[i] = model_mem[i];
    end
    repeat (3) @(posedge CLK_I);
    #1 RST_I = 1'b0;
    @(negedge CLK_I);
    chk("rst_cyc", 64'(CYC_O), 64'd0);
    chk("rst_we", 64'(WE_O), 64'd0);
    chk("rst_adr", 64'(ADR_O), 64'd0);
    chk("rst_dat", 64'(DAT_O), 64'd0);
    chk("rst_sel", 64'(SEL_O), 64'd0);
    chk("rst_rsp", 64'({rsp_valid, rsp_err}), 64'd0);
    chk("rst_rdata", 64'(rsp_rdata), 64'd0);
    chk("rst_ready", 64'(req_ready), 64'd1);

    // Zero-wait write, 3-wait read, ERR+ACK together, watchdog expiry
    do_txn(mk(1'b1, 32'h10, 32'hDEADBEEF, 4'hF, M_ACK, 0), 0, 1'b0);
    p = mk(1'b0, 32'h10, 32'h0, 4'hF, M_ACK, 3);
    p.force_dat = 1'b1; p.dat = 32'h12345678;
    do_txn(p, 0, 1'b0);
    do_txn(mk(1'b0, 32'h14, 32'h0, 4'hF, M_BOTH, 0), 0, 1'b0);
    do_txn(mk(1'b0, 32'h18, 32'h0, 4'hF, M_NONE, 0), 0, 1'b0);

    // Reset during the second wait cycle drops the transaction silently
    p = mk(1'b0, 32'h1C, 32'h0, 4'hF, M_NONE, 0);
    p.abort = 1'b1;
    do_txn(p, 0, 1'b0);
    @(posedge CLK_I);
    @(posedge CLK_I);
    #1 RST_I = 1'b1;
    model_rdata = '0;
    held_rdata  = '0;
    @(posedge CLK_I);
    #1 RST_I = 1'b0;
    prev_inflight = 1'b0;
    @(negedge CLK_I);
    chk("abort_cyc", 64'(CYC_O), 64'd0);
    chk("abort_no_rsp", 64'(rsp_valid), 64'd0);
    chk("abort_ready", 64'(req_ready), 64'd1);
    do_txn(mk(1'b0, 32'h10, 32'h0, 4'hF, M_ACK, 1), 1, 1'b0);

    // Back-to-back write then read of the same word with req_valid held
    do_txn(mk(1'b1, 32'h20, 32'hCAFEF00D, 4'hF, M_ACK, 0), 0, 1'b1);
    do_txn(mk(1'b0, 32'h20, 32'h0, 4'hF, M_ACK, 0), 0, 1'b0);
    do_txn(mk(1'b1, 32'h20, 32'h11223344, 4'b0101, M_ACK, 2), 0, 1'b0);
    do_txn(mk(1'b0, 32'h20, 32'h0, 4'hF, M_ACK, 0), 0, 1'b0);

    for (int n = 0; n < 250; n++) begin
      r = $urandom_range(99);
      p = mk(1'($urandom), {$urandom, 2'b00} & 32'hFFFF_FFFC, $urandom, SW'($urandom),
             (r < 75) ? M_ACK : (r < 87) ? M_ERR : (r < 94) ? M_BOTH : M_NONE,
             ($urandom_range(9) == 0) ? $urandom_range(20) : $urandom_range(3));
      do_txn(p, $urandom_range(2), 1'b0);
    end

    for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge CLK_I);
    repeat (3) @(negedge CLK_I);
    chk("responses_drained", 64'(exp_q.size()), 64'd0);
    chk("plans_drained", 64'(plan_q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
